seven_seg_scan_controller: RTL
==============================

Name: seven_seg_scan_controller

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS display digits.
- Drives the current digit's nibble to the decoder, registers the returned segment pattern, and asserts a one-hot digit select.
- Accepts new display values over a valid/ready handshake. Values are committed only at frame boundaries, so a frame never tears.
- Sits between the system datapath and the external decoder/display pins.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digits (range 2..8).
- SCAN_DIV, 50000, clock cycles per digit slot (must be > BLANK_CYCLES).
- BLANK_CYCLES, 16, anti-ghosting guard cycles at the start of each slot (must be ≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scanning enable.
- value_in  in  4*NUM_DIGITS  display value; nibble k is digit k.
- load_valid  in  1  value_in is valid.
- load_ready  out  1  controller can accept a value.
- hex_out  out  4  nibble to the shared decoder (registered).
- seg_in  in  7  decoder output (combinational from hex_out).
- seg_out  out  7  registered segment drive, active-high.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  single-cycle pulse on frame wrap.

Behaviour:
- Reset (reset low, asynchronous):
  - hex_out, seg_out, digit_sel, frame_done = 0; load_ready = 1.
  - Display register, shadow register and pending flag = 0; state = IDLE; slot counter and digit index = 0.
- Handshake:
  - A transfer occurs on a clock edge where load_valid && load_ready.
  - load_ready = !pending (registered flag). At most one value is held in the shadow register.
- Commit rules:
  - In IDLE, an accepted value goes straight to the display register; pending stays 0.
  - While scanning, an accepted value goes to the shadow register and sets pending.
  - At the frame wrap edge, shadow is copied to display and pending clears.
  - If a transfer coincides with the frame wrap edge, value_in goes directly to the display register and pending stays 0.
- FSM states:
  - IDLE:
    - All outputs low except load_ready; counters held at 0.
    - enable=1 → BLANK, with digit index 0 and hex_out = display nibble 0.
  - BLANK:
    - digit_sel = 0, seg_out = 0; slot counter increments.
    - When counter = BLANK_CYCLES-1 → ON.
  - ON:
    - digit_sel = one-hot(digit index).
    - seg_out captures seg_in every cycle; the first valid pattern is visible on the first ON cycle.
    - When counter = SCAN_DIV-1:
      - counter clears and the index increments, wrapping NUM_DIGITS-1→0.
      - hex_out updates to the new index's nibble → BLANK.
- Frame wrap:
  - On the ON→BLANK edge where the index wraps to 0, frame_done = 1 for exactly one cycle and the pending commit happens.
  - The new digit 0 uses the committed value.
- Slot timing: exactly SCAN_DIV cycles per digit (BLANK_CYCLES blank + SCAN_DIV-BLANK_CYCLES on); frame period = NUM_DIGITS*SCAN_DIV.
- enable deasserted in any state:
  - Next edge → IDLE; digit_sel, seg_out and hex_out are 0 on that edge. No frame_done.
  - A pending value is committed on that edge.
  - Re-enable always restarts at digit 0 BLANK.
- Reset asserted mid-slot or mid-handshake: immediate return to reset values; any pending value is discarded.
- The decoder blanks nibble 0; the controller passes nibble 0 through unchanged and does not substitute it.

Optional Feature:
- Macro: SEVEN_SEG_SCAN_BRIGHTNESS_EN.
- With the macro defined:
  - Extra input port brightness [3:0].
  - During ON, digit_sel and seg_out are forced to 0 once the ON-phase cycle count reaches ((SCAN_DIV-BLANK_CYCLES)*(brightness+1))>>4.
  - brightness is sampled at each BLANK entry and held for the slot.
  - brightness=15 gives full on-time.
- Without the macro: no brightness port; full on-time always.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
1. Reset release, enable=1 → digit_sel 0 for 2 cycles, then 4'b0001 for 6 cycles, then 0 for 2, then 4'b0010. frame_done pulses every 32 cycles.
2. In IDLE, load 16'h1234 → load_ready stays 1. Scan shows hex_out 4,3,2,1 on digits 0..3; seg_out on digit 0 is 7'b1100110.
3. Mid-frame, load 16'hABCD → load_ready drops the next cycle. A second load_valid is not accepted. The remainder of the frame shows the old value; the new value appears from the frame_done edge and load_ready returns to 1.
4. Load handshake on the exact frame wrap edge → the new value appears on digit 0 of the very next frame, and load_ready remains 1.
5. enable low during digit 2 ON → next cycle digit_sel=0, seg_out=0, hex_out=0. Re-enable → restarts at digit 0 BLANK.
6. Reset pulse while pending=1 → all outputs 0 immediately, load_ready=1, and the display value after re-enable is 0 (all segments blank).

Source files
------------

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed 7-segment scan controller: one shared hex decoder, one-hot digit drive, tear-free frame commits.
// Optional macro SEVEN_SEG_SCAN_BRIGHTNESS_EN adds a brightness input that shortens each digit's on-time.
//
// state | meaning
// IDLE  | scanning stopped, all drive low, counters held at zero
// BLANK | guard cycles at slot start, digit and segments off
// ON    | selected digit lit with the registered decoder pattern
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [3:0]              hex_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
    ,
    input  logic [3:0]              brightness
`endif
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pend_q, pend_d;
    logic [3:0]              hex_d;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   sel_d;
    logic                    done_d;

    logic xfer;
    logic slot_last;
    logic idx_last;
    logic commit_edge;
    logic dim_first;
    logic dim_on;

    function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IDX_W-1:0] i);
        return NUM_DIGITS'(1) << i;
    endfunction

    assign load_ready  = !pend_q;
    assign xfer        = load_valid && !pend_q;
    assign slot_last   = (cnt_q == SLOT_LAST);
    assign idx_last    = (idx_q == IDX_LAST);
    // Display may only change where no partially shown frame can be torn.
    assign commit_edge = !enable || ((state_q == ON) && slot_last && idx_last);

`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
    logic [3:0] bright_q;
    logic       blank_entry;
    int         on_limit;
    int         on_next;

    assign blank_entry = (state_d == BLANK) && (state_q != BLANK);

    always_comb begin
        on_limit = ((SCAN_DIV - BLANK_CYCLES) * (int'(bright_q) + 1)) >> 4;
        on_next  = int'(cnt_q) + 1 - BLANK_CYCLES;
    end

    assign dim_first = (on_limit <= 0);
    assign dim_on    = (on_next >= on_limit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bright_q <= '0;
        end else if (blank_entry) begin
            bright_q <= brightness;
        end
    end
`else
    assign dim_first = 1'b0;
    assign dim_on    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        hex_d    = hex_out;
        seg_d    = seg_out;
        sel_d    = digit_sel;
        done_d   = 1'b0;

        if (xfer) begin
            if (commit_edge || (state_q == IDLE)) begin
                disp_d = value_in;
            end else begin
                shadow_d = value_in;
                pend_d   = 1'b1;
            end
        end else if (commit_edge && pend_q) begin
            disp_d = shadow_q;
        end
        if (commit_edge) begin
            pend_d = 1'b0;
        end

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            hex_d   = '0;
            seg_d   = '0;
            sel_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    hex_d   = disp_d[3:0];
                    seg_d   = '0;
                    sel_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    seg_d = '0;
                    sel_d = '0;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        if (!dim_first) begin
                            sel_d = one_hot(idx_q);
                            seg_d = seg_in;
                        end
                    end
                end
                ON: begin
                    seg_d = '0;
                    sel_d = '0;
                    if (slot_last) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_last ? '0 : idx_q + 1'b1;
                        done_d  = idx_last;
                        hex_d   = disp_d[4*idx_d +: 4];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (!dim_on) begin
                            sel_d = one_hot(idx_q);
                            seg_d = seg_in;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    hex_d   = '0;
                    seg_d   = '0;
                    sel_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            hex_out    <= '0;
            seg_out    <= '0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            hex_out    <= hex_d;
            seg_out    <= seg_d;
            digit_sel  <= sel_d;
            frame_done <= done_d;
        end
    end

endmodule
